// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: conditions the raw lines, decodes 11-bit frames
// and tracks make/break prefixes to present the currently held key.
module ps2_scancode_receiver #(
  parameter int FILTER           = 8,
  parameter int TIMEOUT          = 50000,
  parameter bit CLEAR_ON_RELEASE = 1'b1
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] character,
  output logic       new_code,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rxState_t;

  rxState_t    r_state;
  logic [1:0]  r_clkSync;
  logic [1:0]  r_dataSync;
  logic        r_filtClk;
  logic [3:0]  r_filtCnt;
  logic        r_fall;
  logic [3:0]  r_bitCnt;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_stop;
  logic [TW-1:0] r_timer;
  logic        r_brk;
  logic        w_data;
  logic        w_goodFrame;

  assign w_data      = r_dataSync[1];
  assign w_goodFrame = r_stop & (^{r_shift, r_parity});

  // Synchronise both lines; the filtered clock only follows after FILTER agreeing
  // samples, and the strobe is raised on the same edge the filter falls.
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_filtClk  <= 1'b1;
      r_filtCnt  <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_fall     <= 1'b0;
      if (r_clkSync[1] == r_filtClk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == 4'(FILTER - 1)) begin
        r_filtClk <= r_clkSync[1];
        r_filtCnt <= '0;
        r_fall    <= ~r_clkSync[1];
      end else begin
        r_filtCnt <= r_filtCnt + 4'd1;
      end
    end
  end

  // Frame state machine with registered outputs. 0xE0 carries no state: only the
  // low byte of an extended code ever reaches character.
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_stop      <= 1'b0;
      r_timer     <= '0;
      r_brk       <= 1'b0;
      character   <= 8'h00;
      rx_byte     <= 8'h00;
      new_code    <= 1'b0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      new_code    <= 1'b0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_fall) begin
            if (!w_data) begin
              r_state  <= SHIFT;
              r_bitCnt <= 4'd1;
              r_timer  <= '0;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (r_fall) begin
            r_timer  <= '0;
            r_bitCnt <= r_bitCnt + 4'd1;
            if (r_bitCnt <= 4'd8) begin
              r_shift <= {w_data, r_shift[7:1]};
            end else if (r_bitCnt == 4'd9) begin
              r_parity <= w_data;
            end else begin
              r_stop  <= w_data;
              r_state <= CHECK;
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            frame_error <= 1'b1;
            r_state     <= IDLE;
            r_bitCnt    <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        CHECK: begin
          r_state  <= IDLE;
          r_bitCnt <= '0;
          if (w_goodFrame) begin
            rx_byte  <= r_shift;
            rx_valid <= 1'b1;
            if (r_shift == 8'hF0) begin
              r_brk <= 1'b1;
            end else if (r_shift != 8'hE0) begin
              r_brk <= 1'b0;
              if (!r_brk) begin
                if (r_shift != character) begin
                  character <= r_shift;
                  new_code  <= 1'b1;
                end
              end else if (CLEAR_ON_RELEASE && (r_shift == character)) begin
                character <= 8'h00;
                new_code  <= 1'b1;
              end
            end
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench for ps2_scancode_receiver: directed scenarios followed by
// random keystroke streams, compared against a keyboard-level reference model.
module tb_ps2_scancode_receiver;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 200;
  localparam int H       = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] char1, rxByte1, char0, rxByte0;
  logic       newCode1, rxValid1, frameErr1, newCode0, rxValid0, frameErr0;

  int checks = 0;
  int errors = 0;
  int nNew1 = 0, nNew0 = 0, nValid = 0, nErr = 0;
  int expNew1 = 0, expNew0 = 0, expValid = 0, expErr = 0;
  logic [7:0] mChar1 = 8'h00, mChar0 = 8'h00, mRx = 8'h00;
  bit   mBrk = 1'b0;
  int   latency;

  always #5 clock = ~clock;

  ps2_scancode_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .CLEAR_ON_RELEASE(1'b1)) dut1 (
    .Pixelclock(clock), .reset(reset), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
    .character(char1), .new_code(newCode1), .rx_byte(rxByte1), .rx_valid(rxValid1),
    .frame_error(frameErr1));

  ps2_scancode_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .CLEAR_ON_RELEASE(1'b0)) dut0 (
    .Pixelclock(clock), .reset(reset), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
    .character(char0), .new_code(newCode0), .rx_byte(rxByte0), .rx_valid(rxValid0),
    .frame_error(frameErr0));

  // Pulse counters sampled mid-cycle so each one-cycle pulse is seen once.
  always @(negedge clock) begin
    if (newCode1 === 1'b1) nNew1 <= nNew1 + 1;
    if (newCode0 === 1'b1) nNew0 <= nNew0 + 1;
    if (rxValid1 === 1'b1) nValid <= nValid + 1;
    if (frameErr1 === 1'b1) nErr <= nErr + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keyboard-level model: what a held-key tracker should show after a good byte.
  task automatic modelByte(input logic [7:0] b);
    expValid++;
    mRx = b;
    if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else if (b != 8'hE0) begin
      if (!mBrk) begin
        if (b != mChar1) begin mChar1 = b; expNew1++; end
        if (b != mChar0) begin mChar0 = b; expNew0++; end
      end else if (b == mChar1) begin
        mChar1 = 8'h00;
        expNew1++;
      end
      mBrk = 1'b0;
    end
  endtask

  // Drives nBits of a frame (11 = complete); half-period H, data changes while high.
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop,
                               input bit glitch, input int nBits);
    logic [10:0] bits;
    bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
    latency = 0;
    for (int i = 0; i < nBits; i++) begin
      ps2Data = bits[i];
      if (glitch) begin
        tick(14); ps2Clk = 1'b0; tick(3); ps2Clk = 1'b1; tick(3);
      end else begin
        tick(H);
      end
      ps2Clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= H; k++) begin
          tick(1);
          if (rxValid1 === 1'b1 && latency == 0) latency = k;
        end
      end else begin
        tick(H);
      end
      ps2Clk = 1'b1;
    end
    if (nBits == 11) begin
      tick(H);
      if (!badPar && !badStop) modelByte(b);
      else expErr++;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rxByte"}, {24'd0, rxByte1}, {24'd0, mRx});
    checkOutput({tag, "_rxByte0"}, {24'd0, rxByte0}, {24'd0, mRx});
    checkOutput({tag, "_char1"}, {24'd0, char1}, {24'd0, mChar1});
    checkOutput({tag, "_char0"}, {24'd0, char0}, {24'd0, mChar0});
    checkOutput({tag, "_nValid"}, nValid, expValid);
    checkOutput({tag, "_nNew1"}, nNew1, expNew1);
    checkOutput({tag, "_nNew0"}, nNew0, expNew0);
    checkOutput({tag, "_nErr"}, nErr, expErr);
  endtask

  initial begin
    logic [7:0] pool [6];
    logic [7:0] b;
    bit badPar, badStop;
    int errAt;
    pool[0] = 8'h2B; pool[1] = 8'h15; pool[2] = 8'h33;
    pool[3] = 8'h22; pool[4] = 8'hE0; pool[5] = 8'hF0;

    reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    checkOutput("reset_char", {24'd0, char1}, 32'h0);
    checkOutput("reset_rxByte", {24'd0, rxByte1}, 32'h0);
    checkOutput("reset_pulses", {29'd0, newCode1, rxValid1, frameErr1}, 32'h0);

    applyStimulus(8'h2B, 0, 0, 0, 11);
    checkOutput("first_latency", latency, FILTER + 4);
    checkAll("first_2B");

    applyStimulus(8'h2B, 0, 0, 0, 11);
    applyStimulus(8'h2B, 0, 0, 0, 11);
    checkAll("typematic");

    applyStimulus(8'h33, 0, 0, 0, 11);
    checkAll("make_33");
    applyStimulus(8'hF0, 0, 0, 0, 11);
    applyStimulus(8'h33, 0, 0, 0, 11);
    checkAll("break_33");

    applyStimulus(8'h15, 1, 0, 0, 11);
    checkAll("bad_parity");
    applyStimulus(8'h22, 0, 0, 0, 11);
    checkAll("good_22");
    applyStimulus(8'h2B, 0, 1, 0, 11);
    checkAll("bad_stop");

    applyStimulus(8'h15, 0, 0, 0, 5);
    errAt = 0;
    for (int k = 1; k <= TIMEOUT + FILTER + 20; k++) begin
      tick(1);
      if (frameErr1 === 1'b1 && errAt == 0) errAt = H + k;
    end
    expErr++;
    checkOutput("timeout_window", {31'd0, (errAt >= TIMEOUT) && (errAt <= TIMEOUT + FILTER + 4)}, 32'd1);
    checkAll("timeout");
    applyStimulus(8'h15, 0, 0, 0, 11);
    checkAll("after_timeout");

    applyStimulus(8'h2B, 0, 0, 1, 11);
    checkOutput("glitch_latency", latency, FILTER + 4);
    checkAll("glitch");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 6) b = 8'($urandom_range(1, 255));
      else b = pool[$urandom_range(0, 5)];
      badPar  = ($urandom_range(0, 7) == 0);
      badStop = ($urandom_range(0, 9) == 0);
      applyStimulus(b, badPar, badStop, 0, 11);
      if (!badPar && !badStop) checkOutput("rand_latency", latency, FILTER + 4);
      checkAll("rand");
    end

    applyStimulus(8'h22, 0, 0, 0, 11);
    applyStimulus(8'h33, 0, 0, 0, 6);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    mChar1 = 8'h00; mChar0 = 8'h00; mRx = 8'h00; mBrk = 1'b0;
    checkOutput("midreset_pulses", {29'd0, newCode1, rxValid1, frameErr1}, 32'h0);
    tick(2 * H + TIMEOUT);
    checkAll("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
